// File: rtl/fma_rr_scheduler.sv
// Round-robin front end that shares one FMA among NREQ requesters: grant, issue,
// wait for the answer (with timeout), release the FMA, return a tagged response.
module fma_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int FP      = 32,
    parameter int TIMEOUT = 16,
    parameter int GAP     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_in,
    output logic [NREQ-1:0]         req_ready_out,
    input  logic [NREQ*FP-1:0]      req_a_in,
    input  logic [NREQ*FP-1:0]      req_b_in,
    output logic [FP-1:0]           fma_float_0_out,
    output logic [FP-1:0]           fma_float_1_out,
    output logic                    fma_req_out,
    output logic                    fma_busy_out,
    input  logic                    fma_busy_in,
    input  logic                    fma_ready_in,
    input  logic [FP-1:0]           fma_answer_in,
    input  logic                    fma_ovf_in,
    input  logic                    fma_unf_in,
    output logic                    rsp_valid_out,
    input  logic                    rsp_ready_in,
    output logic [$clog2(NREQ)-1:0] rsp_id_out,
    output logic [FP-1:0]           rsp_data_out,
    output logic                    rsp_ovf_out,
    output logic                    rsp_unf_out,
    output logic                    rsp_err_out
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, id_q;
    logic [GW-1:0] gap_q;
    logic [TW-1:0] tmo_q;
    logic          ack_q;
    logic [FP-1:0] a_q, b_q, data_q;
    logic          ovf_q, unf_q, err_q;

    logic [FP-1:0] a_arr [NREQ];
    logic [FP-1:0] b_arr [NREQ];
    logic [IW:0]   cand;
    logic          grant_vld, can_grant, tmo_hit;
    logic [IW-1:0] grant_idx;

    // The FMA's own busy flag carries no extra information: spacing is enforced by the gap timer.
    logic unused_fma_busy;
    assign unused_fma_busy = fma_busy_in;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a_in[gi*FP +: FP];
        assign b_arr[gi] = req_b_in[gi*FP +: FP];
    end

    // First valid requester strictly after the pointer, wrapping NREQ-1 -> 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!grant_vld && req_valid_in[cand[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    assign can_grant = (state_q == S_IDLE) && grant_vld && (gap_q >= GW'(GAP));
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (can_grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (fma_ready_in) state_d = S_ACK;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_ACK:   if (ack_q) state_d = S_RESP;
            S_RESP:  if (rsp_ready_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_out = '0;
        if (can_grant) req_ready_out[grant_idx] = 1'b1;
        fma_req_out   = (state_q == S_ISSUE);
        fma_busy_out  = (state_q == S_ACK);
        rsp_valid_out = (state_q == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= IW'(NREQ - 1);
            gap_q  <= GW'(GAP);
            tmo_q  <= '0;
            ack_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)   gap_q <= '0;
            else if (gap_q < GW'(GAP)) gap_q <= gap_q + GW'(1);
            case (state_q)
                S_IDLE: begin
                    if (can_grant) begin
                        a_q   <= a_arr[grant_idx];
                        b_q   <= b_arr[grant_idx];
                        id_q  <= grant_idx;
                        ptr_q <= grant_idx;
                    end
                end
                S_ISSUE: begin
                    tmo_q <= '0;
                    ack_q <= 1'b0;
                end
                S_WAIT: begin
                    // A ready arriving on the timeout cycle still delivers the real answer.
                    if (fma_ready_in) begin
                        data_q <= fma_answer_in;
                        ovf_q  <= fma_ovf_in;
                        unf_q  <= fma_unf_in;
                        err_q  <= 1'b0;
                    end else if (tmo_hit) begin
                        data_q <= '0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_ACK:   ack_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign fma_float_0_out = a_q;
    assign fma_float_1_out = b_q;
    assign rsp_id_out      = id_q;
    assign rsp_data_out    = data_q;
    assign rsp_ovf_out     = ovf_q;
    assign rsp_unf_out     = unf_q;
    assign rsp_err_out     = err_q;

endmodule

// File: tb/tb_fma_rr_scheduler.sv
// Self-checking bench for fma_rr_scheduler: behavioural FMA responder, requester
// drop-on-grant, and a round-robin reference model built on modular arithmetic.
module tb_fma_rr_scheduler;
    localparam int NREQ = 4, FP = 32, TIMEOUT = 16, GAP = 10, IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid_in, req_ready_out;
    logic [NREQ*FP-1:0] req_a_in, req_b_in;
    logic [FP-1:0]     fma_float_0_out, fma_float_1_out;
    logic              fma_req_out, fma_busy_out, fma_busy_in, fma_ready_in;
    logic [FP-1:0]     fma_answer_in;
    logic              fma_ovf_in, fma_unf_in;
    logic              rsp_valid_out, rsp_ready_in;
    logic [IW-1:0]     rsp_id_out;
    logic [FP-1:0]     rsp_data_out;
    logic              rsp_ovf_out, rsp_unf_out, rsp_err_out;

    fma_rr_scheduler #(.NREQ(NREQ), .FP(FP), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_a_in(req_a_in), .req_b_in(req_b_in),
        .fma_float_0_out(fma_float_0_out), .fma_float_1_out(fma_float_1_out),
        .fma_req_out(fma_req_out), .fma_busy_out(fma_busy_out),
        .fma_busy_in(fma_busy_in), .fma_ready_in(fma_ready_in),
        .fma_answer_in(fma_answer_in), .fma_ovf_in(fma_ovf_in), .fma_unf_in(fma_unf_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_id_out(rsp_id_out), .rsp_data_out(rsp_data_out),
        .rsp_ovf_out(rsp_ovf_out), .rsp_unf_out(rsp_unf_out), .rsp_err_out(rsp_err_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // FMA responder configuration: answer fma_lat cycles after the issue pulse (<=0: never).
    int          fma_lat = -1;
    bit          fma_use_fn = 1'b0;
    logic [31:0] fma_fix_ans = '0;
    logic        fma_fix_ovf = 1'b0, fma_fix_unf = 1'b0;
    bit          keep_valid = 1'b0;

    // Observations gathered by the monitor.
    logic [NREQ-1:0] ready_vec_q[$];
    time             issue_t_q[$];
    logic [31:0]     issue_a_q[$], issue_b_q[$];
    int              req_len_q[$], busy_len_q[$];
    int              multi_hot = 0;

    // Reference state.
    int              mptr = NREQ - 1;
    logic [NREQ-1:0] pending = '0;
    logic [31:0]     op_a [NREQ];
    logic [31:0]     op_b [NREQ];

    // Captured response.
    bit              got;
    logic [IW-1:0]   r_id;
    logic [31:0]     r_data;
    logic            r_ovf, r_unf, r_err;
    time             r_t;

    function automatic logic [31:0] model_fn(input logic [31:0] a, input logic [31:0] b);
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Monitor plus requester behaviour: a granted requester drops its valid after the grant edge.
    initial begin
        int rl, bl;
        logic [NREQ-1:0] g;
        rl = 0; bl = 0;
        forever begin
            @(negedge clk);
            g = req_ready_out;
            if (g != '0) begin
                ready_vec_q.push_back(g);
                if ($countones(g) != 1) multi_hot++;
            end
            if (fma_req_out === 1'b1) begin
                if (rl == 0) begin
                    issue_t_q.push_back($time);
                    issue_a_q.push_back(fma_float_0_out);
                    issue_b_q.push_back(fma_float_1_out);
                end
                rl++;
            end else if (rl != 0) begin
                req_len_q.push_back(rl);
                rl = 0;
            end
            if (fma_busy_out === 1'b1) bl++;
            else if (bl != 0) begin
                busy_len_q.push_back(bl);
                bl = 0;
            end
            @(posedge clk);
            #1;
            if (!keep_valid && !rst) req_valid_in = req_valid_in & ~g;
        end
    end

    // Behavioural FMA: answers with a one-cycle ready pulse.
    initial begin
        int lat;
        logic [31:0] ans;
        fma_ready_in = 1'b0; fma_answer_in = 32'hdeadbeef; fma_ovf_in = 1'b0; fma_unf_in = 1'b0;
        fma_busy_in = 1'b0;
        forever begin
            @(negedge clk);
            if (fma_req_out === 1'b1 && fma_lat > 0) begin
                ans = fma_use_fn ? model_fn(fma_float_0_out, fma_float_1_out) : fma_fix_ans;
                lat = fma_lat;
                repeat (lat) @(posedge clk);
                #1;
                fma_ready_in = 1'b1; fma_answer_in = ans;
                fma_ovf_in = fma_fix_ovf; fma_unf_in = fma_fix_unf;
                @(posedge clk);
                #1;
                fma_ready_in = 1'b0; fma_answer_in = 32'hdeadbeef;
                fma_ovf_in = 1'b0; fma_unf_in = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        ready_vec_q.delete(); issue_t_q.delete(); issue_a_q.delete(); issue_b_q.delete();
        req_len_q.delete(); busy_len_q.delete(); multi_hot = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; req_valid_in = '0; rsp_ready_in = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        mptr = NREQ - 1; pending = '0;
        clear_obs();
    endtask

    task automatic set_valid(input logic [NREQ-1:0] m);
        @(posedge clk); #2;
        req_valid_in = m;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a; op_b[i] = b;
        req_a_in[i*FP +: FP] = a;
        req_b_in[i*FP +: FP] = b;
    endtask

    task automatic wait_valid();
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid_out === 1'b1) got = 1'b1;
        end
        r_id = rsp_id_out; r_data = rsp_data_out;
        r_ovf = rsp_ovf_out; r_unf = rsp_unf_out; r_err = rsp_err_out; r_t = $time;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid_out=%b, required 1 within 200 cycles", rsp_valid_out);
        end
    endtask

    task automatic accept();
        @(negedge clk);
        rsp_ready_in = 1'b1;
        @(posedge clk); #2;
        rsp_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({rsp_valid_out, req_ready_out, fma_req_out, fma_busy_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/ready/req/busy=%b %b %b %b, required all 0",
                     rsp_valid_out, req_ready_out, fma_req_out, fma_busy_out);
        end
        n_tests++;
        if ({fma_float_0_out, fma_float_1_out, rsp_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: f0=%h f1=%h data=%h, required 0", fma_float_0_out, fma_float_1_out, rsp_data_out);
        end
        n_tests++;
        if ({rsp_id_out, rsp_ovf_out, rsp_unf_out, rsp_err_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: id=%0d ovf=%b unf=%b err=%b, required 0", rsp_id_out, rsp_ovf_out, rsp_unf_out, rsp_err_out);
        end
    endtask

    task automatic test_single_op();
        fma_lat = 5; fma_use_fn = 1'b0; fma_fix_ans = 32'h3f800000; fma_fix_ovf = 1'b0; fma_fix_unf = 1'b0;
        set_ops(2, 32'h3f800000, 32'h3f800000);
        clear_obs();
        set_valid(4'b0100);
        wait_valid();
        accept();
        mptr = 2;
        n_tests++;
        if (ready_vec_q.size() != 1 || ready_vec_q[0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready: %0d grant cycles first=%b, required 1 cycle of 0100",
                     ready_vec_q.size(), ready_vec_q.size() > 0 ? ready_vec_q[0] : 4'b0);
        end
        n_tests++;
        if (req_len_q.size() != 1 || req_len_q[0] != 1 || busy_len_q.size() != 1 || busy_len_q[0] != 2) begin
            n_fail++;
            $display("FAIL single_pulses: req pulses=%0d busy runs=%0d (len %0d), required 1 one-cycle req and one 2-cycle busy",
                     req_len_q.size(), busy_len_q.size(), busy_len_q.size() > 0 ? busy_len_q[0] : 0);
        end
        n_tests++;
        if (issue_a_q.size() != 1 || issue_a_q[0] !== 32'h3f800000 || issue_b_q[0] !== 32'h3f800000) begin
            n_fail++;
            $display("FAIL single_operands: issued %0d ops, required A=B=3f800000", issue_a_q.size());
        end
        n_tests++;
        if (r_id !== 2'd2 || r_data !== 32'h3f800000 || {r_ovf, r_unf, r_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_rsp: id=%0d data=%h flags=%b%b%b, required id=2 data=3f800000 flags=000",
                     r_id, r_data, r_ovf, r_unf, r_err);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        time d, dmin;
        do_reset();
        fma_lat = 3; fma_use_fn = 1'b0; fma_fix_ans = 32'hc3960000;
        for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
        keep_valid = 1'b1;
        set_valid(4'hF);
        for (int k = 0; k < 5; k++) begin
            exp = rr_pick(4'hF, mptr);
            mptr = exp;
            wait_valid();
            n_tests++;
            if (r_id !== IW'(exp) || r_data !== 32'hc3960000 || r_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: id=%0d data=%h err=%b, required id=%0d data=c3960000 err=0",
                         k, r_id, r_data, r_err, exp);
            end
            if (k == 4) begin
                keep_valid = 1'b0;
                set_valid('0);
            end
            accept();
        end
        dmin = 1000;
        for (int i = 1; i < issue_t_q.size(); i++) begin
            d = (issue_t_q[i] - issue_t_q[i-1]) / 10;
            if (d < dmin) dmin = d;
        end
        n_tests++;
        if (issue_t_q.size() != 5 || dmin < GAP + 1 || multi_hot != 0) begin
            n_fail++;
            $display("FAIL rr_spacing: issues=%0d min spacing=%0d multi-hot=%0d, required 5 issues spacing>=%0d one-hot",
                     issue_t_q.size(), dmin, multi_hot, GAP + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] s_id;
        logic [31:0]   s_data;
        logic [2:0]    s_fl;
        int            bad;
        fma_lat = 2; fma_use_fn = 1'b0; fma_fix_ans = 32'h40490fdb;
        set_ops(1, $urandom, $urandom);
        set_ops(3, $urandom, $urandom);
        set_valid(4'b0010);
        mptr = 1;
        wait_valid();
        s_id = r_id; s_data = r_data; s_fl = {r_ovf, r_unf, r_err};
        n_tests++;
        if (s_id !== 2'd1 || s_data !== 32'h40490fdb) begin
            n_fail++;
            $display("FAIL bp_first: id=%0d data=%h, required id=1 data=40490fdb", s_id, s_data);
        end
        set_valid(4'b1000);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid_out !== 1'b1 || rsp_id_out !== s_id || rsp_data_out !== s_data ||
                {rsp_ovf_out, rsp_unf_out, rsp_err_out} !== s_fl || req_ready_out !== '0) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: valid=%b id=%0d data=%h ready=%b, required 1 %0d %h 0000",
                         c, rsp_valid_out, rsp_id_out, rsp_data_out, req_ready_out, s_id, s_data);
            end
        end
        accept();
        mptr = rr_pick(4'b1000, mptr);
        wait_valid();
        accept();
        n_tests++;
        if (r_id !== IW'(mptr) || r_data !== 32'h40490fdb) begin
            n_fail++;
            $display("FAIL bp_next: id=%0d data=%h, required id=%0d data=40490fdb", r_id, r_data, mptr);
        end
    endtask

    task automatic test_timeout();
        time d;
        // Never answered: error response.
        fma_lat = -1;
        set_ops(0, $urandom, $urandom);
        mptr = rr_pick(4'b0001, mptr);
        clear_obs();
        set_valid(4'b0001);
        wait_valid();
        d = (issue_t_q.size() > 0) ? (r_t - issue_t_q[0]) / 10 : 0;
        n_tests++;
        if (r_err !== 1'b1 || r_data !== '0 || {r_ovf, r_unf} !== 2'b00 || r_id !== IW'(mptr)) begin
            n_fail++;
            $display("FAIL tmo_rsp: id=%0d data=%h ovf=%b unf=%b err=%b, required id=%0d data=0 flags=0 err=1",
                     r_id, r_data, r_ovf, r_unf, r_err, mptr);
        end
        n_tests++;
        if (d < TIMEOUT || d > TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL tmo_latency: response %0d cycles after issue, required %0d..%0d", d, TIMEOUT, TIMEOUT + 1);
        end
        accept();
        // Ready on the very last waiting cycle beats the timeout.
        fma_lat = TIMEOUT; fma_use_fn = 1'b0; fma_fix_ans = 32'h3f000000;
        set_ops(2, $urandom, $urandom);
        mptr = rr_pick(4'b0100, mptr);
        set_valid(4'b0100);
        wait_valid();
        accept();
        n_tests++;
        if (r_err !== 1'b0 || r_data !== 32'h3f000000 || r_id !== IW'(mptr)) begin
            n_fail++;
            $display("FAIL tmo_race: id=%0d data=%h err=%b, required id=%0d data=3f000000 err=0", r_id, r_data, r_err, mptr);
        end
        // Ready one cycle too late lands outside the wait window and is ignored.
        fma_lat = TIMEOUT + 1;
        mptr = rr_pick(4'b0100, mptr);
        set_valid(4'b0100);
        wait_valid();
        repeat (3) @(negedge clk);
        n_tests++;
        if (rsp_err_out !== 1'b1 || rsp_data_out !== '0 || rsp_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_late_ready: valid=%b data=%h err=%b, required 1 00000000 1", rsp_valid_out, rsp_data_out, rsp_err_out);
        end
        accept();
        // Back to normal service.
        fma_lat = 2; fma_fix_ans = 32'h41200000;
        set_ops(1, $urandom, $urandom);
        mptr = rr_pick(4'b0010, mptr);
        set_valid(4'b0010);
        wait_valid();
        accept();
        n_tests++;
        if (r_err !== 1'b0 || r_data !== 32'h41200000 || r_id !== IW'(mptr)) begin
            n_fail++;
            $display("FAIL tmo_recover: id=%0d data=%h err=%b, required id=%0d data=41200000 err=0", r_id, r_data, r_err, mptr);
        end
    endtask

    task automatic test_flags();
        fma_lat = 4; fma_use_fn = 1'b0; fma_fix_ans = 32'h7f800000; fma_fix_ovf = 1'b1; fma_fix_unf = 1'b0;
        mptr = rr_pick(4'b1000, mptr);
        set_valid(4'b1000);
        wait_valid();
        accept();
        n_tests++;
        if (r_ovf !== 1'b1 || r_unf !== 1'b0 || r_err !== 1'b0 || r_data !== 32'h7f800000) begin
            n_fail++;
            $display("FAIL flags_ovf: data=%h ovf=%b unf=%b err=%b, required 7f800000 1 0 0", r_data, r_ovf, r_unf, r_err);
        end
        fma_fix_ans = 32'h00000000; fma_fix_ovf = 1'b0; fma_fix_unf = 1'b1;
        mptr = rr_pick(4'b0001, mptr);
        set_valid(4'b0001);
        wait_valid();
        accept();
        n_tests++;
        if (r_ovf !== 1'b0 || r_unf !== 1'b1 || r_err !== 1'b0 || r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL flags_unf: data=%h ovf=%b unf=%b err=%b, required 00000000 0 1 0", r_data, r_ovf, r_unf, r_err);
        end
        fma_fix_unf = 1'b0;
    endtask

    task automatic test_reset_wait();
        int seen;
        int exp;
        fma_lat = -1;
        clear_obs();
        set_valid(4'b0100);
        for (int i = 0; i < 60 && issue_t_q.size() == 0; i++) @(negedge clk);
        n_tests++;
        if (issue_t_q.size() == 0) begin
            n_fail++;
            $display("FAIL rstw_issue: issues=0, required 1 before reset");
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; req_valid_in = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        mptr = NREQ - 1;
        @(negedge clk);
        n_tests++;
        if ({rsp_valid_out, req_ready_out, fma_req_out, fma_busy_out, rsp_err_out, rsp_data_out,
             fma_float_0_out, fma_float_1_out, rsp_id_out} !== '0) begin
            n_fail++;
            $display("FAIL rstw_outputs: valid=%b req=%b busy=%b f0=%h data=%h, required all 0",
                     rsp_valid_out, fma_req_out, fma_busy_out, fma_float_0_out, rsp_data_out);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid_out !== 1'b0 || fma_req_out !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstw_silent: %0d active cycles after reset, required 0", seen);
        end
        fma_lat = 3; fma_use_fn = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
        pending = 4'hF;
        set_valid(pending);
        for (int k = 0; k < NREQ; k++) begin
            exp = rr_pick(pending, mptr);
            mptr = exp;
            pending[exp] = 1'b0;
            wait_valid();
            accept();
            n_tests++;
            if (r_id !== IW'(exp) || r_data !== model_fn(op_a[exp], op_b[exp]) || r_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rstw_order[%0d]: id=%0d data=%h, required id=%0d data=%h",
                         k, r_id, r_data, exp, model_fn(op_a[exp], op_b[exp]));
            end
        end
    endtask

    task automatic add_reqs(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++)
            if (m[i] && !pending[i]) set_ops(i, $urandom, $urandom);
        pending = pending | m;
        set_valid(pending);
    endtask

    task automatic test_random();
        int exp;
        time d, dmin;
        clear_obs();
        fma_use_fn = 1'b1; fma_fix_ovf = 1'b0; fma_fix_unf = 1'b0;
        fma_lat = $urandom_range(1, 8);
        for (int it = 0; it < 24 && (it < 16 || pending != '0); it++) begin
            if (pending == '0) add_reqs(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            exp = rr_pick(pending, mptr);
            mptr = exp;
            pending[exp] = 1'b0;
            wait_valid();
            n_tests++;
            if (r_id !== IW'(exp) || r_data !== model_fn(op_a[exp], op_b[exp]) || {r_ovf, r_unf, r_err} !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_op[%0d]: id=%0d data=%h err=%b, required id=%0d data=%h err=0",
                         it, r_id, r_data, r_err, exp, model_fn(op_a[exp], op_b[exp]));
            end
            if (it < 16) add_reqs(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
            fma_lat = $urandom_range(1, 8);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            accept();
        end
        dmin = 1000;
        for (int i = 1; i < issue_t_q.size(); i++) begin
            d = (issue_t_q[i] - issue_t_q[i-1]) / 10;
            if (d < dmin) dmin = d;
        end
        n_tests++;
        if (dmin < GAP + 1 || multi_hot != 0) begin
            n_fail++;
            $display("FAIL rand_spacing: min issue spacing=%0d multi-hot=%0d, required >=%0d and 0", dmin, multi_hot, GAP + 1);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid_in = '0; rsp_ready_in = 1'b0;
        req_a_in = '0; req_b_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_flags();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
